// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: MIPS instruction-fetch stage.
// Owns the PC, fetches over a ready handshake into a one-entry buffer
// that feeds IF/ID, and applies decode-stage redirects (jr, j/jal, taken
// branch) after the branch delay slot.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall_F,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        branchD,
   input  logic        zeroD,
   input  logic [15:0] imm16D,
   input  logic        jumpD,
   input  logic [25:0] index26D,
   input  logic        jrD,
   input  logic [31:0] rsD,
   input  logic [31:0] pcD,
   output logic [31:0] instrF,
   output logic [31:0] pcF,
   output logic        validF
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // one-entry fetch buffer contents
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } fbuf_t;

   state_t      r_state;
   state_t      w_state_nxt;
   fbuf_t       r_buf;
   logic [31:0] r_pc;
   logic        r_pending;
   logic [31:0] r_pend_target;

   logic        w_req;
   logic        w_fire;
   logic        w_drain;
   logic        w_redir;
   logic [31:0] w_pcd_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_target;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // next state and request: IDLE spends exactly one cycle silent after reset
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      case (r_state)
         S_IDLE: w_state_nxt = S_RUN;
         S_RUN:  w_req       = !r_buf.valid || !stall_F;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_fire  = w_req && imem_ready;
   assign w_drain = r_buf.valid && !stall_F;

   // a redirect is only taken when D actually advances this edge
   assign w_redir = !stall_F && (jrD || jumpD || (branchD && zeroD));

   assign w_pcd_plus4 = pcD + 32'd4;
   assign w_br_off    = {{14{imm16D[15]}}, imm16D, 2'b00};

   // redirect target, jr wins over jump, jump wins over branch
   always_comb begin
      w_target = w_pcd_plus4 + w_br_off;
      if (jrD)        w_target = rsD;
      else if (jumpD) w_target = {w_pcd_plus4[31:28], index26D, 2'b00};
   end

   // fetch buffer: capture on fire, empty on drain; a word fetched on the
   // same edge a redirect retires the delay slot from the buffer is wrong-path
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_buf.instr <= '0;
         r_buf.pc    <= RESET_PC;
         r_buf.valid <= 1'b0;
      end else if (w_fire) begin
         if (w_redir && r_buf.valid) begin
            r_buf.valid <= 1'b0;
         end else begin
            r_buf.instr <= imem_rdata;
            r_buf.pc    <= r_pc;
            r_buf.valid <= 1'b1;
         end
      end else if (w_drain) begin
         r_buf.valid <= 1'b0;
      end
   end

   // PC and deferred redirect: if the delay slot is neither buffered nor
   // being fetched, park the target until the slot has been fetched
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc          <= RESET_PC;
         r_pending     <= 1'b0;
         r_pend_target <= '0;
      end else if (w_redir) begin
         if (r_buf.valid || w_fire) begin
            r_pc      <= w_target;
            r_pending <= 1'b0;
         end else begin
            r_pending     <= 1'b1;
            r_pend_target <= w_target;
         end
      end else if (w_fire) begin
         r_pc      <= r_pending ? r_pend_target : r_pc + 32'd4;
         r_pending <= 1'b0;
      end
   end

   assign imem_req  = w_req;
   assign imem_addr = r_pc;
   assign instrF    = r_buf.instr;
   assign pcF       = r_buf.pc;
   assign validF    = r_buf.valid;

endmodule
